// File: rtl/cordic_iter_ctrl.sv
// Sequencer for the shared iterative CORDIC vectoring datapath: handshakes one
// operand in, steps the micro-rotation counter, strobes post-correction and holds the result.
module cordic_iter_ctrl #(
  parameter int N_ITER  = 14,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         quadrant_in,
  output logic               dp_load,
  output logic               dp_iter_en,
  output logic [SHIFT_W-1:0] dp_shift,
  output logic [SHIFT_W-1:0] dp_atan_addr,
  output logic               dp_post_en,
  output logic [2:0]         quadrant_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err_quadrant
);

  typedef enum logic [1:0] {IDLE, ITER, POST, DONE} state_t;

  localparam logic [SHIFT_W-1:0] LAST_ITER = SHIFT_W'(N_ITER - 1);

  state_t             state_reg, state_next;
  logic [SHIFT_W-1:0] iter_reg, iter_next;
  logic [2:0]         quad_reg, quad_next;
  logic               err_reg, err_next;
  logic               acc;
  logic               quad_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      iter_reg  <= '0;
      quad_reg  <= 3'd1;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
      quad_reg  <= quad_next;
      err_reg   <= err_next;
    end
  end

  assign quad_legal = (quadrant_in >= 3'd1) && (quadrant_in <= 3'd4);

  always_comb begin
    state_next   = state_reg;
    iter_next    = iter_reg;
    quad_next    = quad_reg;
    err_next     = err_reg;
    dp_iter_en   = 1'b0;
    dp_shift     = '0;
    dp_post_en   = 1'b0;
    out_valid    = 1'b0;

    in_ready = !reset && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    acc      = in_valid && in_ready;
    dp_load  = acc;

    // Illegal codes still start an operation but are folded to quadrant 1.
    if (acc) begin
      quad_next = quad_legal ? quadrant_in : 3'd1;
      err_next  = err_reg || !quad_legal;
    end

    case (state_reg)
      IDLE: begin
        if (acc) begin
          state_next = ITER;
          iter_next  = '0;
        end
      end
      ITER: begin
        dp_iter_en = 1'b1;
        dp_shift   = iter_reg;
        if (iter_reg == LAST_ITER) begin
          state_next = POST;
          iter_next  = '0;
        end else begin
          iter_next = iter_reg + SHIFT_W'(1);
        end
      end
      POST: begin
        dp_post_en = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = acc ? ITER : IDLE;
          iter_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    busy         = (state_reg != IDLE);
    quadrant_out = quad_reg;
    err_quadrant = err_reg;

    // Every output reads zero while reset is held, even the registered ones.
    if (reset) begin
      dp_iter_en   = 1'b0;
      dp_shift     = '0;
      dp_post_en   = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      quadrant_out = 3'd0;
      err_quadrant = 1'b0;
    end
  end

  assign dp_atan_addr = dp_shift;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: single op, back-to-back, backpressure,
// illegal quadrant, mid-operation reset and idle behaviour.
module tb_cordic_iter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] quadrant_in;
  logic       dp_load;
  logic       dp_iter_en;
  logic [3:0] dp_shift;
  logic [3:0] dp_atan_addr;
  logic       dp_post_en;
  logic [2:0] quadrant_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       err_quadrant;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_iter_ctrl #(.N_ITER(14), .SHIFT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .quadrant_in(quadrant_in), .dp_load(dp_load), .dp_iter_en(dp_iter_en),
    .dp_shift(dp_shift), .dp_atan_addr(dp_atan_addr), .dp_post_en(dp_post_en),
    .quadrant_out(quadrant_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err_quadrant(err_quadrant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then let outputs settle.
  task automatic step(input logic v, input logic [2:0] q, input logic r);
    @(posedge clk);
    #1;
    in_valid    = v;
    quadrant_in = q;
    out_ready   = r;
    #1;
  endtask

  function automatic logic [31:0] obs_pack();
    return {18'd0, in_ready, dp_load, dp_iter_en, dp_shift, dp_atan_addr,
            dp_post_en, out_valid, busy};
  endfunction

  function automatic logic [31:0] mk(input logic ir, input logic ld, input logic ie,
                                     input logic [3:0] sh, input logic pe,
                                     input logic ov, input logic bz);
    return {18'd0, ir, ld, ie, sh, sh, pe, ov, bz};
  endfunction

  // Expected outputs of an isolated op accepted in cycle 0 from IDLE with out_ready=1.
  function automatic logic [31:0] single_exp(input int k);
    logic ie;
    ie = (k >= 1) && (k <= 14);
    return mk((k == 0) || (k >= 16), k == 0, ie, ie ? 4'(k - 1) : 4'd0,
              k == 15, k == 16, (k >= 1) && (k <= 16));
  endfunction

  task automatic run_single(input string tag, input logic [2:0] q_acc,
                            input logic [2:0] exp_q, input logic exp_err);
    for (int k = 0; k <= 17; k++) begin
      // quadrant_in carries an illegal code while not accepted; it must be ignored
      step(k == 0, (k == 0) ? q_acc : 3'd7, 1'b1);
      chk($sformatf("%s pack k=%0d", tag, k), obs_pack(), single_exp(k));
      if (k == 16) begin
        chk($sformatf("%s quad", tag), 32'(quadrant_out), 32'(exp_q));
        chk($sformatf("%s err", tag), 32'(err_quadrant), 32'(exp_err));
      end
    end
    $display("op %s q_in=%0d -> quadrant_out=%0d err=%0d", tag, q_acc, exp_q, exp_err);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; quadrant_in = 3'd0; out_ready = 1'b0;

    // Reset held with in_valid high: every output is zero.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 3'd2, 1'b1);
      chk($sformatf("rst pack k=%0d", k), obs_pack(), 32'd0);
      chk($sformatf("rst quad k=%0d", k), {29'd0, quadrant_out, err_quadrant}, 32'd0);
    end
    @(posedge clk); #1; reset = 1'b0; in_valid = 1'b0; #1;
    chk("post-rst pack", obs_pack(), mk(1, 0, 0, 4'd0, 0, 0, 0));
    chk("post-rst quad", 32'(quadrant_out), 32'd1);
    chk("post-rst err", 32'(err_quadrant), 32'd0);

    run_single("single", 3'd3, 3'd3, 1'b0);

    // Back-to-back: second operand taken in the first op's DONE cycle.
    for (int k = 0; k <= 33; k++) begin
      step(k <= 16, (k == 0) ? 3'd2 : 3'd4, 1'b1);
      chk($sformatf("b2b ov k=%0d", k), 32'(out_valid), 32'((k == 16) || (k == 32)));
      chk($sformatf("b2b ld k=%0d", k), 32'(dp_load), 32'((k == 0) || (k == 16)));
      if (k == 16) chk("b2b quad1", 32'(quadrant_out), 32'd2);
      if (k == 17) chk("b2b iter restart", 32'({dp_iter_en, dp_shift}), 32'h10);
      if (k == 32) chk("b2b quad2", 32'(quadrant_out), 32'd4);
    end
    $display("op b2b q=2,4 out_valid at 16 and 32");

    // Backpressure: out_ready low for five DONE cycles while in_valid pokes at it.
    for (int k = 0; k <= 22; k++) begin
      if (k <= 15) step(k == 0, 3'd1, 1'b1);
      else if (k <= 20) step(1'b1, 3'd3, 1'b0);
      else step(1'b0, 3'd3, 1'b1);
      if (k <= 15) chk($sformatf("bp pack k=%0d", k), obs_pack(), single_exp(k));
      else begin
        chk($sformatf("bp ov k=%0d", k), 32'(out_valid), 32'(k <= 21));
        chk($sformatf("bp ir k=%0d", k), 32'(in_ready), 32'(k >= 21));
        chk($sformatf("bp ld k=%0d", k), 32'(dp_load), 32'd0);
        chk($sformatf("bp quad k=%0d", k), 32'(quadrant_out), 32'd1);
        chk($sformatf("bp busy k=%0d", k), 32'(busy), 32'(k <= 21));
      end
    end
    $display("op backpressure q=1 out_valid held 6 cycles");

    // Illegal quadrant folds to 1 and sets the sticky flag.
    run_single("illegal", 3'd0, 3'd1, 1'b1);
    run_single("after-illegal", 3'd2, 3'd2, 1'b1);

    // Reset at iteration 7 aborts the op.
    for (int k = 0; k <= 8; k++) begin
      step(k == 0, 3'd3, 1'b1);
      if (k == 8) begin
        chk("abort pre-rst shift", 32'(dp_shift), 32'd7);
        reset = 1'b1; #1;
        chk("abort rst pack", obs_pack(), 32'd0);
        chk("abort rst quad", {29'd0, quadrant_out, err_quadrant}, 32'd0);
      end
    end
    step(1'b0, 3'd0, 1'b1);
    chk("abort rst2 pack", obs_pack(), 32'd0);
    @(posedge clk); #1; reset = 1'b0; #1;
    $display("op abort at iteration 7");

    // Idle after reset: nothing moves, err cleared, no stale result.
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 3'd5, 1'b1);
      chk($sformatf("idle pack k=%0d", k), obs_pack(), mk(1, 0, 0, 4'd0, 0, 0, 0));
      if (k == 19) begin
        chk("idle quad", 32'(quadrant_out), 32'd1);
        chk("idle err", 32'(err_quadrant), 32'd0);
      end
    end
    $display("idle 20 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
